// File: rtl/dmem_wbuf.sv
// Posted write buffer and single-port SRAM arbiter for the RV32IM data-memory port.
// Loads win the port unless the buffer is full or the load hits a buffered store.
module dmem_wbuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 14
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          dmem_wready,
  output logic          dmem_wvalid,
  input  logic [31:0]   dmem_waddr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  input  logic          dmem_rready,
  output logic          dmem_rvalid,
  input  logic [31:0]   dmem_raddr,
  output logic          dmem_rresp,
  output logic [31:0]   dmem_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          wbuf_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    strb_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pending_q;
  logic [31:0]   hold_q;

  logic [AW-1:0] waddr_w, raddr_w;
  logic          full, empty, w_acc, push, pop, hit;
  logic [PW-1:0] off;

  assign waddr_w = dmem_waddr[AW+1:2];
  assign raddr_w = dmem_raddr[AW+1:2];

  // Address bits outside the word index alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmem_waddr[31:AW+2], dmem_waddr[1:0],
                              dmem_raddr[31:AW+2], dmem_raddr[1:0]};

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign wbuf_empty  = empty;
  assign dmem_wvalid = !full;
  assign w_acc       = dmem_wready && !full;
  assign push        = w_acc && (dmem_wstrb != 4'h0);

  // Entry i is live when its distance from the head is below the count.
  always_comb begin
    hit = w_acc && (waddr_w == raddr_w);
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (addr_q[i] == raddr_w)) begin
        hit = 1'b1;
      end
    end
  end

  assign dmem_rvalid = dmem_rready && !hit && !full;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    if (full || (!dmem_rvalid && !empty)) begin
      mem_en    = 1'b1;
      mem_we    = strb_q[rd_ptr_q];
      mem_addr  = addr_q[rd_ptr_q];
      mem_wdata = data_q[rd_ptr_q];
      pop       = 1'b1;
    end else if (dmem_rvalid) begin
      mem_en   = 1'b1;
      mem_addr = raddr_w;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= dmem_rvalid;
      if (pending_q) begin
        hold_q <= mem_rdata;
      end
    end
  end

  // Payload storage needs no reset; liveness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= waddr_w;
      data_q[wr_ptr_q] <= dmem_wdata;
      strb_q[wr_ptr_q] <= dmem_wstrb;
    end
  end

  assign dmem_rresp = pending_q;
  assign dmem_rdata = pending_q ? mem_rdata : hold_q;

endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Posted write buffer plus SRAM port arbiter between the top-level data-memory interface of the RV32IM core and a single-port synchronous data SRAM.
- Stores are accepted with zero wait while there is space, and drain to SRAM in idle cycles.
- Loads take the SRAM port with priority, except when the buffer is full or the load address hits a buffered store.
- Read-after-write ordering is preserved by holding conflicting loads until the matching stores have drained.

Parameters:
DEPTH, 4, number of write-buffer entries (power of two, >=2)
AW, 14, SRAM word-address width (SRAM size = 4*2^AW bytes)

Ports:
clk  in  1  clock
resetb  in  1  asynchronous active-low reset
dmem_wready  in  1  core write request
dmem_wvalid  out  1  write accepted this cycle
dmem_waddr  in  32  write byte address
dmem_wdata  in  32  write data
dmem_wstrb  in  4  byte enables
dmem_rready  in  1  core read request
dmem_rvalid  out  1  read accepted this cycle
dmem_raddr  in  32  read byte address
dmem_rresp  out  1  read data valid (cycle after acceptance)
dmem_rdata  out  32  read data
mem_en  out  1  SRAM access enable
mem_we  out  4  SRAM byte write enables (0 = read)
mem_addr  out  AW  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid one cycle after a read access
wbuf_empty  out  1  buffer holds no entries (used for fence/drain)

Behaviour:
- Clock and reset: clock clk; reset resetb, asynchronous, active-low.
- Reset values:
  - FIFO empty: wbuf_empty=1.
  - rresp=0, rdata hold register=0, read-pending flag=0.
  - A reset mid-operation discards all buffered stores.
- Word address: addr[AW+1:2]. Bits [31:AW+2] are ignored, so addresses alias.
- dmem_wvalid = !full, combinational, registered-state based.
  - A write is accepted when wready && wvalid.
  - On acceptance, {word addr, wdata, wstrb} is pushed at the clock edge.
  - wstrb==0: accepted but not pushed.
- Hit: raddr word address equals the word address of any valid entry, or of a write accepted in the same cycle.
  - Byte lanes are not considered; any word match is a hit.
- dmem_rvalid = rready && !hit && !full, combinational.
- Port arbitration, per cycle, in priority order:
  1. full: drain head.
  2. accepted read: mem_en=1, mem_we=0, mem_addr=raddr word; pending is set.
  3. FIFO non-empty: drain head (mem_en=1, mem_we=head strb, mem_addr/mem_wdata from head; pop at the edge).
  4. Otherwise mem_en=0, and mem_we, mem_addr, mem_wdata are 0.
- Hit read:
  - Not accepted; the core keeps rready asserted.
  - Drain proceeds in FIFO order.
  - The read is accepted in the first cycle in which no matching entry remains.
- Read return:
  - In the cycle after acceptance: rresp=1 and dmem_rdata=mem_rdata (combinational pass-through); the hold register captures the value.
  - Other cycles: rresp=0, and rdata shows the hold register.
- Write latency: the earliest SRAM write is the cycle after acceptance. Push and pop in the same cycle leave the count unchanged.
- Full:
  - wvalid=0.
  - Head drains that cycle, so wvalid returns to 1 the next cycle.
  - Reads are not accepted while full. This guarantees forward progress for stores.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- Drain order is strictly FIFO. Multiple entries to the same word are all written, in order; no merging.
- Simultaneous write request and read request with no hit and not full: both are accepted, and the read takes the port.

Test Plan:
- Write 0x100 data 0xDEADBEEF strb 0xF on an idle, empty bus -> wvalid=1 the same cycle; next cycle mem_en=1, mem_we=0xF, mem_addr=0x40, mem_wdata=0xDEADBEEF; wbuf_empty returns to 1 the following cycle.
- 4 back-to-back writes to 0x200..0x20C, each with a read to 0x300 asserted in the same cycles -> reads win the port. Once full:
  - wvalid=0 and rvalid=0.
  - Drains 0x80, 0x81 ... proceed in order.
  - No write is lost; final SRAM contents match.
- Write 0x400 data 0x11223344 strb 0x3, then read 0x400 the next cycle -> rvalid=0 until the entry drains (mem_we=0x3); then rvalid=1; next cycle rresp=1 and rdata=SRAM word with low half 0x3344.
- Read miss 0x500 with SRAM word 0xCAFEF00D -> rvalid=1 the same cycle, mem_en=1, mem_we=0; next cycle rresp=1 and rdata=0xCAFEF00D; the cycle after, rresp=0 and rdata holds 0xCAFEF00D.
- Write with wstrb=0 -> accepted (wvalid=1), no SRAM access, wbuf_empty stays 1.
- Fill with 3 entries, assert resetb=0 mid-drain -> immediately wbuf_empty=1, mem_en=0, rresp=0; after release no stale write reaches SRAM.
